// File: rtl/sram_model_if.sv
// sram_model_if: address / write-enable bundle of the external 16-bit
// asynchronous SRAM bus. The controller drives it (master) and the
// on-chip responder samples it (slave). SRAM_DQ is bidirectional, so it
// stays a plain inout port on the responder. That way the tristate
// resolves on an ordinary module boundary.
interface sram_model_if #(
    parameter int ADDR_W = 18
) ();
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N;

    modport master (output SRAM_ADDR, output SRAM_WE_N);
    modport slave  (input  SRAM_ADDR, input  SRAM_WE_N);
endinterface

// File: rtl/sram_model.sv
// sram_model: synthesizable stand-in for the external asynchronous SRAM.
// - Writes are captured on the rising clock edge.
// - Reads are driven back on SRAM_DQ after READ_LAT cycles. A value of 0
//   gives a combinational read.
// - Two 16-bit wrapping counters track bus activity for debug.
// - Addresses wrap modulo DEPTH.
// Optional build macro SRAM_MODEL_RANGE_CHECK_EN adds two ports:
// - range_err: sticky out-of-range flag.
// - err_addr: low 16 bits of the first offending address.
module sram_model #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    sram_model_if.slave        bus,
    inout  wire [DATA_W-1:0]   SRAM_DQ,
    output logic [15:0]        wr_count,
    output logic [15:0]        rd_count
`ifdef SRAM_MODEL_RANGE_CHECK_EN
    ,
    output logic               range_err,
    output logic [15:0]        err_addr
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx_s;
    logic              wr_en_s;
    logic              drive_en_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              rd_vld_s;
    logic [DATA_W-1:0] dq_out_s;

    logic [15:0]       wr_count_d, wr_count_q;
    logic [15:0]       rd_count_d, rd_count_q;

    // Index aliasing and bus-direction decode
    always_comb begin
        idx_s      = bus.SRAM_ADDR[IDX_W-1:0];
        wr_en_s    = rst & ~bus.SRAM_WE_N;
        drive_en_s = rst & bus.SRAM_WE_N;
    end

    // Word array capture; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= SRAM_DQ;
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_rd
            // Zero latency: the live address selects the word directly
            always_comb begin
                rd_idx_s = idx_s;
                rd_vld_s = 1'b1;
            end
        end else begin : g_pipe_rd
            logic [IDX_W-1:0]    ap_d [READ_LAT];
            logic [IDX_W-1:0]    ap_q [READ_LAT];
            logic [READ_LAT-1:0] v_d;
            logic [READ_LAT-1:0] v_q;

            // Shift address/valid one stage per edge; a write cycle enters as an invalid slot
            always_comb begin
                ap_d[0] = idx_s;
                v_d[0]  = bus.SRAM_WE_N;
                for (int i = 1; i < READ_LAT; i++) begin
                    ap_d[i] = ap_q[i-1];
                    v_d[i]  = v_q[i-1];
                end
            end

            // Pipeline registers, flushed by reset so nothing in flight survives it
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < READ_LAT; i++) begin
                        ap_q[i] <= {IDX_W{1'b0}};
                    end
                    v_q <= {READ_LAT{1'b0}};
                end else begin
                    ap_q <= ap_d;
                    v_q  <= v_d;
                end
            end

            // The array is read at the last stage, so a younger write to the same word wins
            always_comb begin
                rd_idx_s = ap_q[READ_LAT-1];
                rd_vld_s = v_q[READ_LAT-1];
            end
        end
    endgenerate

    // Read data: an empty slot returns zero rather than stale data
    always_comb begin
        if (rd_vld_s) begin
            dq_out_s = mem[rd_idx_s];
        end else begin
            dq_out_s = {DATA_W{1'b0}};
        end
    end

    assign SRAM_DQ = drive_en_s ? dq_out_s : {DATA_W{1'bz}};

    // Activity counters: accepted writes, and cycles spent driving a valid word
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_en_s) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
        if (drive_en_s && rd_vld_s) begin
            rd_count_d = rd_count_q + 16'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

`ifdef SRAM_MODEL_RANGE_CHECK_EN
    logic        addr_oob_s;
    logic        range_err_d, range_err_q;
    logic [15:0] err_addr_d, err_addr_q;

    generate
        if (IDX_W < ADDR_W) begin : g_oob
            assign addr_oob_s = |bus.SRAM_ADDR[ADDR_W-1:IDX_W];
        end else begin : g_no_oob
            assign addr_oob_s = 1'b0;
        end
    endgenerate

    // Sticky flag; only the first offending address is latched
    always_comb begin
        range_err_d = range_err_q;
        err_addr_d  = err_addr_q;
        if (addr_oob_s && !range_err_q) begin
            range_err_d = 1'b1;
            err_addr_d  = 16'(bus.SRAM_ADDR);
        end else begin
            range_err_d = range_err_q;
            err_addr_d  = err_addr_q;
        end
    end

    // Range-check registers, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            range_err_q <= 1'b0;
            err_addr_q  <= 16'd0;
        end else begin
            range_err_q <= range_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign range_err = range_err_q;
    assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_sram_model.sv
// tb_sram_model: drives one address/write-enable bus into two responders.
// - u_lat0 is built with READ_LAT=0.
// - u_lat2 is built with READ_LAT=2.
// Each responder has its own data bus. The bench drives the same write
// data onto both buses, so the two arrays hold the same contents.
// Expected values are queued with the cycle they apply to, and a monitor
// compares them on the falling edge.
`timescale 1ns/1ps
module tb_sram_model;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    localparam int S_DQ0 = 0;
    localparam int S_DQ2 = 1;
    localparam int S_WR0 = 2;
    localparam int S_RD0 = 3;
    localparam int S_WR2 = 4;
    localparam int S_RD2 = 5;
    localparam int S_RE0 = 6;
    localparam int S_EA0 = 7;
    localparam int S_RE2 = 8;
    localparam int S_EA2 = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_model_if #(.ADDR_W(ADDR_W)) bus ();

    logic        tb_drv;
    logic [15:0] tb_dq;
    wire  [15:0] dq0;
    wire  [15:0] dq2;
    assign dq0 = tb_drv ? tb_dq : 16'hzzzz;
    assign dq2 = tb_drv ? tb_dq : 16'hzzzz;

    logic [15:0] wr0, rd0, wr2, rd2;
`ifdef SRAM_MODEL_RANGE_CHECK_EN
    logic        re0, re2;
    logic [15:0] ea0, ea2;
`endif

    sram_model #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq0), .wr_count(wr0), .rd_count(rd0)
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        , .range_err(re0), .err_addr(ea0)
`endif
    );

    sram_model #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(dq2), .wr_count(wr2), .rd_count(rd2)
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        , .range_err(re2), .err_addr(ea2)
`endif
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        bit          released;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] obs(input int sel);
        case (sel)
            S_DQ0:   return dq0;
            S_DQ2:   return dq2;
            S_WR0:   return wr0;
            S_RD0:   return rd0;
            S_WR2:   return wr2;
            S_RD2:   return rd2;
`ifdef SRAM_MODEL_RANGE_CHECK_EN
            S_RE0:   return {15'd0, re0};
            S_EA0:   return ea0;
            S_RE2:   return {15'd0, re2};
            S_EA2:   return ea2;
`endif
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_DQ0:   return "dq_lat0";
            S_DQ2:   return "dq_lat2";
            S_WR0:   return "wr_count_lat0";
            S_RD0:   return "rd_count_lat0";
            S_WR2:   return "wr_count_lat2";
            S_RD2:   return "rd_count_lat2";
            S_RE0:   return "range_err_lat0";
            S_EA0:   return "err_addr_lat0";
            S_RE2:   return "range_err_lat2";
            S_EA2:   return "err_addr_lat2";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                exp_t        e;
                logic [15:0] act;
                bit          ok;
                e   = sb_q.pop_front();
                act = obs(e.sel);
                if (e.cyc < cyc) begin
                    ok = 1'b0;
                end else if (e.released) begin
                    // a released bus floats (reads back as 0 on a two-state simulator)
                    ok = (act === 16'hzzzz) || (act === 16'h0000);
                end else begin
                    ok = (act === e.exp);
                end
                n_vec++;
                if (!ok) begin
                    n_err++;
                    if (e.released)
                        $display("FAIL %s cyc=%0d got=%h want=released", sel_name(e.sel), e.cyc, act);
                    else
                        $display("FAIL %s cyc=%0d got=%h want=%h", sel_name(e.sel), e.cyc, act, e.exp);
                end
            end
        end
    end

    task automatic step(input logic r, input logic we_n, input logic [ADDR_W-1:0] a,
                        input logic [15:0] d);
        rst           = r;
        bus.SRAM_WE_N = we_n;
        bus.SRAM_ADDR = a;
        tb_drv        = ~we_n;
        tb_dq         = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expv(input int sel, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.exp = v; e.released = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic expz(input int sel);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.exp = 16'h0000; e.released = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        step(1'b1, 1'b1, a, 16'h0000);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    initial begin
        step(1'b0, 1'b0, 18'd5, 16'h1234);
        tick();
        // reset held with a write forced onto the bus
        step(1'b0, 1'b0, 18'd5, 16'h1234);
        expv(S_WR0, 16'd0); expv(S_RD0, 16'd0); expv(S_WR2, 16'd0); expv(S_RD2, 16'd0);
        tick();
        wr(18'd5, 16'h5555); tick();
        rd(18'd5); expv(S_DQ0, 16'h5555); expv(S_WR0, 16'd1); expv(S_DQ2, 16'h0000); tick();
        // reset mid-operation: bus released, counters cleared at once
        step(1'b0, 1'b1, 18'd5, 16'h0000);
        expz(S_DQ0); expz(S_DQ2); expv(S_WR0, 16'd0); expv(S_RD0, 16'd0); tick();
        step(1'b0, 1'b0, 18'd5, 16'h1234); expv(S_WR0, 16'd0); tick();
        // after release: array unchanged, latency-2 output zero for two cycles
        rd(18'd5); expv(S_DQ0, 16'h5555); expv(S_DQ2, 16'h0000); tick();
        rd(18'd5); expv(S_DQ2, 16'h0000); tick();
        rd(18'd5); expv(S_DQ2, 16'h5555); expv(S_RD0, 16'd2); expv(S_RD2, 16'd0); tick();
        // write then read, and a suppressed slot that is not replayed
        wr(18'd5, 16'hBEEF); expv(S_RD2, 16'd1); tick();
        rd(18'd5); expv(S_DQ0, 16'hBEEF); expv(S_WR0, 16'd1); expv(S_DQ2, 16'hBEEF); tick();
        rd(18'd5); expv(S_DQ0, 16'hBEEF); expv(S_DQ2, 16'h0000); tick();
        // 32-bit word pair 0xCAFEF00D at words 4/5
        wr(18'd4, 16'hF00D); expv(S_RD0, 16'd5); expv(S_RD2, 16'd2); tick();
        wr(18'd5, 16'hCAFE); tick();
        rd(18'd4); expv(S_DQ0, 16'hF00D); expv(S_WR0, 16'd3); expv(S_WR2, 16'd3);
        expv(S_DQ2, 16'h0000); tick();
        rd(18'd5); expv(S_DQ0, 16'hCAFE); tick();
        rd(18'd5); expv(S_DQ2, 16'hF00D); tick();
        rd(18'd5); expv(S_DQ2, 16'hCAFE); tick();
        // pipelined reads of 1,2,3
        wr(18'd1, 16'h0011); tick();
        wr(18'd2, 16'h0022); tick();
        wr(18'd3, 16'h0033); tick();
        rd(18'd1); expv(S_DQ0, 16'h0011); tick();
        rd(18'd2); expv(S_DQ0, 16'h0022); tick();
        rd(18'd3); expv(S_DQ0, 16'h0033); expv(S_DQ2, 16'h0011); tick();
        rd(18'd1); expv(S_DQ2, 16'h0022); tick();
        rd(18'd1); expv(S_DQ2, 16'h0033); tick();
        // write lands while a read of the same word is in flight
        rd(18'd3); expv(S_DQ0, 16'h0033); tick();
        wr(18'd3, 16'h0099); tick();
        rd(18'd1); expv(S_DQ2, 16'h0099); expv(S_DQ0, 16'h0011); tick();
        rd(18'd1); expv(S_DQ2, 16'h0000);
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        expv(S_RE0, 16'd0); expv(S_RE2, 16'd0);
`endif
        tick();
        // address wrap: 4096+7 aliases word 7
        wr(18'h01007, 16'hA5A5); tick();
        rd(18'd7); expv(S_DQ0, 16'hA5A5);
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        expv(S_RE0, 16'd1); expv(S_EA0, 16'h1007); expv(S_RE2, 16'd1); expv(S_EA2, 16'h1007);
`endif
        tick();
        rd(18'h02007); expv(S_DQ0, 16'hA5A5); tick();
        rd(18'd7); expv(S_DQ2, 16'hA5A5);
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        expv(S_EA0, 16'h1007); expv(S_RE0, 16'd1);
`endif
        tick();
        rd(18'd7); expv(S_DQ2, 16'hA5A5); tick();
        rd(18'd7); expv(S_DQ2, 16'hA5A5); tick();
        // counter wrap: clear, 65535 writes, then one more
        step(1'b0, 1'b1, 18'd0, 16'h0000); expv(S_WR0, 16'd0);
`ifdef SRAM_MODEL_RANGE_CHECK_EN
        expv(S_RE0, 16'd0);
`endif
        tick();
        for (int i = 0; i < 65535; i++) begin
            wr(18'd100, 16'(i));
            tick();
        end
        rd(18'd100); expv(S_WR0, 16'hFFFF); expv(S_WR2, 16'hFFFF); expv(S_DQ0, 16'hFFFE); tick();
        wr(18'd100, 16'h7777); tick();
        rd(18'd100); expv(S_WR0, 16'h0000); expv(S_WR2, 16'h0000); expv(S_DQ0, 16'h7777); tick();
        rd(18'd100); tick();
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
            tick();
        end
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_model.md
Name: sram_model

Overview:
- Synthesizable on-chip responder for the external 16-bit asynchronous SRAM bus: SRAM_ADDR, SRAM_WE_N and bidirectional SRAM_DQ.
- Lets the SRAM controller, and the ARM core behind it, run in simulation and on FPGA builds without the physical chip.
- Holds a word array and captures writes on the clock edge. Drives read data onto SRAM_DQ with configurable latency, and keeps access-count status for debug.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- DEPTH, 4096, words actually stored; power of two; must be <= 2**ADDR_W.
- READ_LAT, 0, read latency in cycles, legal 0..3. 0 means asynchronous/combinational read, which matches the controller's load timing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_ADDR  in  ADDR_W  word address from the controller.
- SRAM_WE_N  in  1  write enable, active low.
- SRAM_DQ  inout  DATA_W  data bus; driven by the controller when SRAM_WE_N=0, by this block otherwise.
- wr_count  out  16  number of write cycles accepted.
- rd_count  out  16  number of read data words driven.

Behaviour:
- Reset:
  - rst=0 asynchronously clears wr_count, rd_count, the address pipeline and the valid pipeline to 0.
  - SRAM_DQ is Z while rst=0.
  - Array contents are not reset.
- Index: idx = SRAM_ADDR mod DEPTH, i.e. the low log2(DEPTH) bits. Addresses >= DEPTH alias (wrap) silently.
- Write:
  - At a rising clk with rst=1 and SRAM_WE_N=0: mem[idx] <= SRAM_DQ; wr_count <= wr_count+1.
  - One word per cycle; back-to-back writes allowed every cycle.
  - SRAM_DQ is Z whenever SRAM_WE_N=0 (no contention).
- Read, READ_LAT=0:
  - SRAM_DQ = mem[idx] combinationally whenever SRAM_WE_N=1 and rst=1.
  - A write at edge k is visible on SRAM_DQ from the cycle after edge k.
- Read, READ_LAT=N>=1:
  - Address pipeline ap[0..N-1] and valid pipeline v[0..N-1].
  - Each edge: ap[0]<=idx, v[0]<=SRAM_WE_N; ap[i]<=ap[i-1], v[i]<=v[i-1].
  - When SRAM_WE_N=1: SRAM_DQ = v[N-1] ? mem[ap[N-1]] : 0.
  - The array is read at the output stage, so read-after-write to the same index returns the new data even while the read is in flight.
  - If SRAM_WE_N=0 in the current cycle, the output is suppressed (Z). That pipeline slot is still consumed and is not replayed.
- rd_count:
  - Increments at each rising edge where this block is actively driving a valid word: SRAM_WE_N=1 and (READ_LAT=0, or v[N-1]=1).
  - With READ_LAT=0, every idle cycle with SRAM_WE_N=1 counts. The counter is a bus-activity metric, not a transaction count.
- Counters: 16-bit, wrap 0xFFFF -> 0x0000, no saturation.
- Reset mid-operation: a write on the same edge that rst is asserted is dropped; in-flight reads are discarded; SRAM_DQ goes Z immediately.
- Release of rst: the first SRAM_DQ value with READ_LAT>=1 is 0 until the pipeline fills.
- No state machine beyond the pipelines; the block is a pure responder and never stalls the controller.

Optional Feature:
- Macro: SRAM_MODEL_RANGE_CHECK_EN.
- Defined:
  - Adds output port range_err (1 bit, reset 0).
  - range_err is sticky: set at any rising edge where rst=1 and SRAM_ADDR >= DEPTH, on either read or write. Cleared only by rst.
  - Adds 16-bit output err_addr, holding the low 16 bits of the first offending SRAM_ADDR.
- Undefined: neither port exists, and aliasing is silent.

Test Plan:
- Reset: hold rst=0 with SRAM_WE_N=0, SRAM_DQ forced 0x1234 -> wr_count=0 and mem unchanged; after release with WE_N=1, READ_LAT=2 -> SRAM_DQ=0x0000 for 2 cycles.
- Write/read, READ_LAT=0: write 0xBEEF at address 5, then raise SRAM_WE_N with address 5 -> SRAM_DQ=0xBEEF in the same cycle; wr_count=1.
- Controller pairing: drive 32-bit write 0xCAFEF00D to CPU address 1024+8 -> words 4/5 hold 0xF00D/0xCAFE; the following read returns read_data=0xCAFEF00D with ready after 5 cycles.
- Pipeline, READ_LAT=2: reads of addresses 1,2,3 on consecutive cycles, holding mem 0x11,0x22,0x33 -> SRAM_DQ shows 0x11,0x22,0x33 two cycles after each address; a write of 0x99 to address 3 in the middle cycle -> third read returns 0x99.
- Wrap: DEPTH=4096; write 0xA5A5 at address 4096+7 -> read at address 7 returns 0xA5A5; with SRAM_MODEL_RANGE_CHECK_EN, range_err=1 and err_addr=0x1007.
- Counter wrap: preload wr_count to 0xFFFF via 65535 writes, then one more write -> wr_count=0x0000.
